// File: rtl/mips_data_mem.sv
// Word-organised data RAM for the MIPS datapath with a request/ready handshake,
// programmable wait states, byte-lane writes and registered address-error reporting.
module mips_data_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [3:0]  byteEnable,
  output logic [31:0] readData,
  output logic        ready,
  output logic        addrError
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        req, accept, complete;

  logic [31:0] lat_addr, lat_data;
  logic [3:0]  lat_be;
  logic        lat_write, lat_conflict;

  logic [31:0] offset;
  logic        in_range, access_error, do_write;
  logic [AW-1:0] index;
  logic [31:0] lane_mask;

  logic [31:0] mem [DEPTH_WORDS];

  assign req = memRead | memWrite;

  // Range test is done on the byte offset so no address bit is ever ignored:
  // offset >> 2 < DEPTH_WORDS  <=>  offset < 4 * DEPTH_WORDS.
  assign offset       = lat_addr - BASE_ADDR;
  assign in_range     = (lat_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
  assign access_error = (lat_addr[1:0] != 2'b00) || !in_range || lat_conflict;
  assign index        = offset[AW+1:2];
  assign lane_mask    = {{8{lat_be[3]}}, {8{lat_be[2]}}, {8{lat_be[1]}}, {8{lat_be[0]}}};
  assign do_write     = !reset && complete && lat_write && !access_error;

  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          count_next = WAIT_INIT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == '0) begin
          complete   = 1'b1;
          state_next = DONE;
        end else begin
          count_next = count - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      ready     <= 1'b0;
      addrError <= 1'b0;
      readData  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      ready <= complete;
      if (complete) begin
        if (access_error) begin
          readData  <= '0;
          addrError <= 1'b1;
        end else begin
          addrError <= 1'b0;
          if (!lat_write) readData <= mem[index];
        end
      end
    end
  end

  // Request fields are captured once; later changes on the bus are ignored.
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_addr     <= address;
      lat_data     <= writeData;
      lat_be       <= byteEnable;
      lat_write    <= memWrite;
      lat_conflict <= memRead & memWrite;
    end
  end

  always_ff @(posedge clock) begin
    if (do_write) mem[index] <= (mem[index] & ~lane_mask) | (lat_data & lane_mask);
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// Randomised and directed bench for mips_data_mem: three instances with
// 2, 0 and 15 wait states are checked against an array-based memory model.
`timescale 1ns/1ps
module tb_mips_data_mem;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int          NI    = 3;

  function automatic int unsigned ws_of(int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic [NI-1:0] rd, wr, ready, aerr;
  logic [31:0]   addr [NI];
  logic [31:0]   wdata[NI];
  logic [31:0]   rdata[NI];
  logic [3:0]    be   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mips_data_mem #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(ws_of(g))
    ) dut (
      .clock     (clock),
      .reset     (reset),
      .memRead   (rd[g]),
      .memWrite  (wr[g]),
      .address   (addr[g]),
      .writeData (wdata[g]),
      .byteEnable(be[g]),
      .readData  (rdata[g]),
      .ready     (ready[g]),
      .addrError (aerr[g])
    );
  end

  logic [31:0] model [NI][DEPTH];
  logic [31:0] rd_exp[NI];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int sel, input logic [9:0] idx, input logic [31:0] v);
    case (sel)
      0:       g_dut[0].dut.mem[idx] = v;
      1:       g_dut[1].dut.mem[idx] = v;
      default: g_dut[2].dut.mem[idx] = v;
    endcase
    model[sel][idx] = v;
  endtask

  function automatic logic is_err(input logic [31:0] a, input logic both);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (a < BASE) || (off >= DEPTH * 4) || both;
  endfunction

  // Full transaction: drive request, wait for ready, compare with the model.
  task automatic access(input int sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input string tag,
                        output logic [31:0] got);
    int          lat;
    logic        bad;
    logic [9:0]  idx;
    lat = -1;
    @(negedge clock);
    rd[sel] = r; wr[sel] = w; addr[sel] = a; wdata[sel] = d; be[sel] = b;
    @(posedge clock);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clock); #1;
      if (ready[sel]) lat = n;
    end
    check({tag, " latency"}, lat, ws_of(sel) + 1);
    bad = is_err(a, r & w);
    idx = 10'((a - BASE) >> 2);
    if (bad) rd_exp[sel] = '0;
    else if (w) begin
      for (int l = 0; l < 4; l++)
        if (b[l]) model[sel][idx][8*l +: 8] = d[8*l +: 8];
    end else rd_exp[sel] = model[sel][idx];
    check({tag, " addrError"}, aerr[sel], bad);
    check({tag, " readData"}, rdata[sel], rd_exp[sel]);
    got = rdata[sel];
    rd[sel] = 1'b0; wr[sel] = 1'b0;
    @(posedge clock); #1;
    check({tag, " ready fall"}, ready[sel], 1'b0);
  endtask

  // Read held through completion must be re-accepted at edge WAIT_STATES+3.
  task automatic held_read(input int sel, input logic [31:0] a);
    int first, second;
    int unsigned ws;
    ws = ws_of(sel);
    first = -1; second = -1;
    @(negedge clock);
    rd[sel] = 1'b1; wr[sel] = 1'b0; addr[sel] = a; be[sel] = 4'h0;
    @(posedge clock);
    for (int n = 1; n <= 2 * int'(ws) + 8 && second < 0; n++) begin
      @(posedge clock); #1;
      if (ready[sel]) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    rd[sel] = 1'b0;
    rd_exp[sel] = model[sel][10'((a - BASE) >> 2)];
    check("held first ready", first, ws + 1);
    check("held second ready", second, 2 * ws + 4);
    check("held readData", rdata[sel], rd_exp[sel]);
    @(posedge clock); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, a, d;
    logic [3:0]  b;
    logic        r, w;
    int          kind;

    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0; rd_exp[i] = '0;
    end
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < int'(DEPTH); j++) poke(i, 10'(j), $urandom);
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset ready", ready[i], 1'b0);
      check("reset addrError", aerr[i], 1'b0);
      check("reset readData", rdata[i], 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Round trip and latency sweep on every wait-state setting.
    for (int i = 0; i < NI; i++) begin
      access(i, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, "rt write", got);
      access(i, 1'b1, 1'b0, 32'h1001_0008, '0, 4'h0, "rt read", got);
      check("rt value", got, 32'hDEAD_BEEF);
      held_read(i, 32'h1001_0008);
    end

    poke(0, 10'd1, 32'h1122_3344);
    access(0, 1'b0, 1'b1, 32'h1001_0004, 32'hAABB_CCDD, 4'b0101, "lane write", got);
    access(0, 1'b1, 1'b0, 32'h1001_0004, '0, 4'h0, "lane read", got);
    check("lane value", got, 32'h11BB_33DD);

    access(0, 1'b1, 1'b0, 32'h1001_000A, '0, 4'h0, "misaligned", got);
    access(0, 1'b1, 1'b0, 32'h1001_1000, '0, 4'h0, "index 1024", got);
    access(0, 1'b1, 1'b0, 32'h1000_FFFC, '0, 4'h0, "below base", got);
    access(0, 1'b1, 1'b0, 32'h1001_0FFC, '0, 4'h0, "last word", got);
    access(0, 1'b1, 1'b1, 32'h1001_0008, 32'h0BAD_0BAD, 4'hF, "both req", got);
    access(0, 1'b1, 1'b0, 32'h1001_0008, '0, 4'h0, "after errors", got);
    check("after errors value", got, 32'hDEAD_BEEF);

    // Abort: write dropped after edge 1, next request sampled at edge 3.
    @(negedge clock);
    wr[0] = 1'b1; addr[0] = 32'h1001_0010; wdata[0] = 32'hCAFE_F00D; be[0] = 4'hF;
    @(posedge clock);
    @(posedge clock); #1;
    wr[0] = 1'b0;
    check("abort no ready e1", ready[0], 1'b0);
    @(posedge clock); #1;
    check("abort no ready e2", ready[0], 1'b0);
    access(0, 1'b1, 1'b0, 32'h1001_0010, '0, 4'h0, "abort read", got);

    // Reset landing on edge 2 of a write.
    @(negedge clock);
    wr[0] = 1'b1; addr[0] = 32'h1001_0020; wdata[0] = 32'h5555_AAAA; be[0] = 4'hF;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < NI; i++) rd_exp[i] = '0;
    check("midreset ready", ready[0], 1'b0);
    check("midreset readData", rdata[0], 32'h0);
    check("midreset addrError", aerr[0], 1'b0);
    reset = 1'b0; wr[0] = 1'b0;
    access(0, 1'b1, 1'b0, 32'h1001_0020, '0, 4'h0, "midreset read", got);

    // Randomised traffic.
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 50; t++) begin
        kind = int'($urandom_range(0, 11));
        r = $urandom_range(0, 1) == 1;
        w = !r;
        a = BASE + ($urandom_range(0, DEPTH - 1) << 2);
        d = $urandom;
        b = 4'($urandom_range(0, 15));
        case (kind)
          0: a = a | 32'($urandom_range(1, 3));
          1: a = BASE + DEPTH * 4 + ($urandom_range(0, 255) << 2);
          2: a = BASE - 4 - ($urandom_range(0, 255) << 2);
          3: begin r = 1'b1; w = 1'b1; end
          default: ;
        endcase
        repeat ($urandom_range(0, 2)) @(posedge clock);
        access(i, r, w, a, d, b, "random", got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
